// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 16-bit async SRAM between the display
// read path and the UART frame-buffer write path. Every SRAM pin is
// registered and read/write cycles follow fixed timing. Reads have priority.
// Defining SRAM_ARB_STARVE_EN adds a guard that forces a pending write
// through after STARVE_LIMIT read grants in a row.
module sram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int RD_CYCLES    = 2,
  parameter int WR_CYCLES    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic              busy,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  // One counter serves both the read strobe and the write pulse, so it is
  // sized for whichever of the two lasts longer.
  localparam int CNT_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dout;
  logic              drive;
  logic              force_wr;
  logic              grant_rd;
  logic              grant_wr;

  // The bus is only ever driven from a register, and only during the
  // write setup/pulse/hold window.
  assign sram_data = drive ? dout : {DATA_W{1'bz}};

`ifdef SRAM_ARB_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign force_wr = wr_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Count reads granted over a waiting write; any write grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_wr) begin
      starve_cnt <= '0;
    end else if (grant_rd && wr_req) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`else
  // Strict read priority: a write may wait for as long as reads keep coming.
  localparam int unused_starve_limit = STARVE_LIMIT;

  assign force_wr = 1'b0;
`endif

  assign grant_rd = (state == IDLE) && rd_req && !force_wr;
  assign grant_wr = (state == IDLE) && wr_req && !grant_rd;

  // Access sequencer: drives every SRAM pin and the acks from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_addr <= '0;
      dout      <= '0;
      drive     <= 1'b0;
      rd_ack    <= 1'b0;
      wr_ack    <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state     <= RD;
            cnt       <= CNT_W'(1);
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_lb_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_addr <= rd_addr;
            busy      <= 1'b1;
          end else if (grant_wr) begin
            state     <= WR_SETUP;
            sram_ce_n <= 1'b0;
            sram_lb_n <= ~wr_be[0];
            sram_ub_n <= ~wr_be[1];
            sram_addr <= wr_addr;
            dout      <= wr_data;
            drive     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RD: begin
          if (cnt == CNT_W'(RD_CYCLES)) begin
            state     <= DONE;
            rd_data   <= sram_data;
            rd_ack    <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          cnt       <= CNT_W'(1);
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == CNT_W'(WR_CYCLES)) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_HOLD: begin
          state     <= DONE;
          wr_ack    <= 1'b1;
          drive     <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          drive     <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit async SRAM between two requesters: the display read path (pixel fetch, clk_read domain already synchronised upstream) and the UART frame-buffer write path.
- Owns every SRAM pin (ce/oe/we/lb/ub/addr/data) and sequences read and write cycles with fixed timing.
- Reads win by default.
- Sits between uart_top's receive buffer, the pixel fetch logic and the board SRAM pins.

Parameters:
- ADDR_W, 19, SRAM address width
- DATA_W, 16, SRAM data width
- RD_CYCLES, 2, cycles oe_n held low per read (>=1)
- WR_CYCLES, 2, cycles we_n held low per write (>=1)
- STARVE_LIMIT, 8, consecutive read grants tolerated while a write waits (used only with SRAM_ARB_STARVE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rd_req  in  1  read request; held high with rd_addr stable until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle
- rd_data  out  DATA_W  captured read word; holds until next read completes
- wr_req  in  1  write request; held high with wr_addr/wr_data/wr_be stable until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write word
- wr_be  in  2  byte enables, [0]=low byte, [1]=high byte, active-high
- wr_ack  out  1  one-cycle pulse at write completion
- busy  out  1  high in any state other than IDLE
- sram_ce_n  out  1  chip enable
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable
- sram_lb_n  out  1  low-byte enable
- sram_ub_n  out  1  high-byte enable
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data, tristated unless writing

Behaviour:
- Reset (async, any state): state=IDLE; ce_n=oe_n=we_n=lb_n=ub_n=1; sram_addr=0; sram_data=Z; rd_ack=wr_ack=0; rd_data=0; busy=0; starve counter=0. An in-flight access is abandoned with no ack; requesters re-issue.
- All SRAM pins are registered; no combinational path from request inputs to pins.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - ce_n/oe_n/we_n=1; bus Z.
  - Grant on a clock edge.
  - Read wins when rd_req is high, unless a write is forced (see Optional Feature).
  - Otherwise, if wr_req is high, grant the write.
  - Address, data and byte enables are latched at the grant.
- RD:
  - ce_n=0, oe_n=0, lb_n=ub_n=0; addr=latched rd_addr.
  - Lasts RD_CYCLES cycles.
  - On the edge ending the last RD cycle, sram_data is sampled into rd_data and the FSM goes to DONE.
- WR_SETUP, 1 cycle: ce_n=0, we_n=1, oe_n=1; addr and data driven; lb_n=~be[0], ub_n=~be[1].
- WR_PULSE, WR_CYCLES cycles: as WR_SETUP but we_n=0.
- WR_HOLD, 1 cycle: we_n=1; addr and data still driven. Then DONE.
- DONE, 1 cycle:
  - All controls deasserted; bus Z.
  - rd_ack or wr_ack=1 for the completed access; state returns to IDLE.
  - Requests are ignored in DONE, so the acked requester can drop its req.
- Latency:
  - rd_req seen at IDLE edge k -> rd_ack high in cycle k+RD_CYCLES+1.
  - Write grant at edge k -> wr_ack in cycle k+WR_CYCLES+3.
- Bus turnaround: sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. oe_n is never 0 while the bus is driven.
- Simultaneous rd_req and wr_req in IDLE: the read is granted and the write waits with wr_req held.
- wr_be=2'b00: the full write sequence still runs with lb_n=ub_n=1; wr_ack is still issued.
- Requests deasserted before ack are a protocol violation; the latched access completes anyway.
- busy=0 only in IDLE.

Optional Feature:
- Macro: SRAM_ARB_STARVE_EN.
- Defined:
  - An internal counter increments on each read grant made while wr_req is high, and clears on any write grant.
  - When the counter equals STARVE_LIMIT, the next IDLE grant goes to the write even if rd_req is high.
  - Counter width is clog2(STARVE_LIMIT+1).
- Undefined: strict read priority; the counter logic is absent; a write may wait indefinitely under continuous reads.

Test Plan:
- Reset mid-write: assert rst during WR_PULSE -> same cycle we_n=1, ce_n=1, bus Z, no wr_ack; after release, busy=0.
- Single read: rd_addr=0x00123 with SRAM model returning 0xBEEF, rd_req at IDLE edge k -> ce_n/oe_n low for 2 cycles, addr=0x00123; rd_ack=1 with rd_data=0xBEEF in cycle k+3.
- Single write: wr_addr=0x7FFFF, wr_data=0xA55A, wr_be=2'b01 -> 1 setup cycle, we_n low 2 cycles, 1 hold cycle; lb_n=0, ub_n=1; model low byte=0x5A, high byte unchanged; wr_ack in cycle k+5.
- Collision: rd_req and wr_req rise in the same cycle -> read completes first; write granted in the IDLE cycle after the read's DONE; bus never driven while oe_n=0.
- Starvation with SRAM_ARB_STARVE_EN, STARVE_LIMIT=8: rd_req held high continuously while wr_req pending -> write granted after exactly 8 read acks.
- Starvation without SRAM_ARB_STARVE_EN: same stimulus -> no wr_ack over 100 reads.
